// File: rtl/cci_mpf_shim_rob.sv
// Read-response reorder buffer: tags AFU reads with ROB slot indices on the way
// to QLP and returns the responses to the AFU in request order, or passes through.
module cci_mpf_shim_rob #(
    parameter int SORT_READ_RESPONSES = 1,
    parameter int N_ENTRIES           = 64,
    parameter int ADDR_WIDTH          = 42,
    parameter int MDATA_WIDTH         = 16,
    parameter int DATA_WIDTH          = 512,
    parameter int ALMOST_FULL_SLACK   = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,

    input  logic                   afu_rd_req_valid,
    input  logic [ADDR_WIDTH-1:0]  afu_rd_req_addr,
    input  logic [MDATA_WIDTH-1:0] afu_rd_req_mdata,
    output logic                   afu_rd_req_almost_full,

    output logic                   qlp_rd_req_valid,
    output logic [ADDR_WIDTH-1:0]  qlp_rd_req_addr,
    output logic [MDATA_WIDTH-1:0] qlp_rd_req_mdata,
    input  logic                   qlp_rd_req_almost_full,

    input  logic                   qlp_rd_rsp_valid,
    input  logic [MDATA_WIDTH-1:0] qlp_rd_rsp_mdata,
    input  logic [DATA_WIDTH-1:0]  qlp_rd_rsp_data,

    output logic                   afu_rd_rsp_valid,
    output logic [MDATA_WIDTH-1:0] afu_rd_rsp_mdata,
    output logic [DATA_WIDTH-1:0]  afu_rd_rsp_data,

    output logic                   rob_error
);

    generate
        if (SORT_READ_RESPONSES != 0) begin : g_sort
            localparam int IDX_W = $clog2(N_ENTRIES);
            localparam logic [IDX_W:0] FULL_OCC = (IDX_W+1)'(N_ENTRIES);
            localparam logic [IDX_W:0] AF_OCC   = (IDX_W+1)'(N_ENTRIES - ALMOST_FULL_SLACK);

            // Pointers carry one extra wrap bit so full and empty are distinguishable.
            logic [IDX_W:0]         head, tail, occupancy, occupancy_next;
            logic [IDX_W-1:0]       head_idx, tail_idx, rsp_idx, rsp_rel;
            logic [N_ENTRIES-1:0]   ready;
            logic                   req_accept, req_drop, rsp_accept, rsp_drop, drain;
            logic                   unused_rsp_mdata;

            logic [MDATA_WIDTH-1:0] meta_ram [N_ENTRIES];
            logic [DATA_WIDTH-1:0]  data_ram [N_ENTRIES];

            assign head_idx         = head[IDX_W-1:0];
            assign tail_idx         = tail[IDX_W-1:0];
            assign rsp_idx          = qlp_rd_rsp_mdata[IDX_W-1:0];
            assign unused_rsp_mdata = ^qlp_rd_rsp_mdata;

            // NOTE: every variable gets a value on every path through always_comb,
            // which is what keeps synthesis from inferring a latch.
            always_comb begin
                occupancy  = tail - head;
                rsp_rel    = rsp_idx - head_idx;
                req_accept = afu_rd_req_valid && (occupancy != FULL_OCC);
                req_drop   = afu_rd_req_valid && (occupancy == FULL_OCC);
                // A slot is live when its distance from head is below the occupancy.
                rsp_accept = qlp_rd_rsp_valid && ({1'b0, rsp_rel} < occupancy) && !ready[rsp_idx];
                rsp_drop   = qlp_rd_rsp_valid && !rsp_accept;
                drain      = ready[head_idx];
                occupancy_next = occupancy;
                if (req_accept) occupancy_next = occupancy_next + 1'b1;
                if (drain)      occupancy_next = occupancy_next - 1'b1;
            end

            // NOTE: sequential state uses non-blocking assignments only, so every
            // register samples the pre-edge value of every other register.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    head                   <= '0;
                    tail                   <= '0;
                    ready                  <= '0;
                    qlp_rd_req_valid       <= 1'b0;
                    afu_rd_rsp_valid       <= 1'b0;
                    afu_rd_req_almost_full <= 1'b0;
                    rob_error              <= 1'b0;
                end else begin
                    qlp_rd_req_valid       <= req_accept;
                    afu_rd_rsp_valid       <= drain;
                    afu_rd_req_almost_full <= (occupancy_next >= AF_OCC) || qlp_rd_req_almost_full;
                    if (req_accept) tail <= tail + 1'b1;
                    if (drain) begin
                        head            <= head + 1'b1;
                        ready[head_idx] <= 1'b0;
                    end
                    if (rsp_accept)           ready[rsp_idx] <= 1'b1;
                    if (req_drop || rsp_drop) rob_error      <= 1'b1;
                end
            end

            // NOTE: RAMs and payload registers have no reset; valid bits and
            // pointers alone define what is live, and this keeps RAMs mappable.
            always_ff @(posedge clk) begin
                if (req_accept) begin
                    meta_ram[tail_idx] <= afu_rd_req_mdata;
                    qlp_rd_req_addr    <= afu_rd_req_addr;
                    qlp_rd_req_mdata   <= MDATA_WIDTH'(tail_idx);
                end
                if (rsp_accept) data_ram[rsp_idx] <= qlp_rd_rsp_data;
                if (drain) begin
                    afu_rd_rsp_mdata <= meta_ram[head_idx];
                    afu_rd_rsp_data  <= data_ram[head_idx];
                end
            end
        end else begin : g_pass
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    qlp_rd_req_valid       <= 1'b0;
                    afu_rd_rsp_valid       <= 1'b0;
                    afu_rd_req_almost_full <= 1'b0;
                    rob_error              <= 1'b0;
                end else begin
                    qlp_rd_req_valid       <= afu_rd_req_valid;
                    afu_rd_rsp_valid       <= qlp_rd_rsp_valid;
                    afu_rd_req_almost_full <= qlp_rd_req_almost_full;
                    rob_error              <= 1'b0;
                end
            end

            always_ff @(posedge clk) begin
                qlp_rd_req_addr  <= afu_rd_req_addr;
                qlp_rd_req_mdata <= afu_rd_req_mdata;
                afu_rd_rsp_mdata <= qlp_rd_rsp_mdata;
                afu_rd_rsp_data  <= qlp_rd_rsp_data;
            end
        end
    endgenerate

endmodule

// File: tb/tb_cci_mpf_shim_rob.sv
// Directed bench for cci_mpf_shim_rob: a sorting instance (8 slots, slack 2)
// and a pass-through instance, driven from a vector table plus corner sequences.
module tb_cci_mpf_shim_rob;
    localparam int N  = 8;
    localparam int SL = 2;
    localparam int AW = 16;
    localparam int MW = 8;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // sorting instance
    logic          s_req_v, s_af, s_qlp_v, s_qlp_af, s_rsp_v, s_afu_v, s_err;
    logic [AW-1:0] s_req_addr, s_qlp_addr;
    logic [MW-1:0] s_req_md, s_qlp_md, s_rsp_md, s_afu_md;
    logic [DW-1:0] s_rsp_data, s_afu_data;

    // pass-through instance
    logic          p_req_v, p_af, p_qlp_v, p_qlp_af, p_rsp_v, p_afu_v, p_err;
    logic [AW-1:0] p_req_addr, p_qlp_addr;
    logic [MW-1:0] p_req_md, p_qlp_md, p_rsp_md, p_afu_md;
    logic [DW-1:0] p_rsp_data, p_afu_data;

    cci_mpf_shim_rob #(.SORT_READ_RESPONSES(1), .N_ENTRIES(N), .ADDR_WIDTH(AW),
                       .MDATA_WIDTH(MW), .DATA_WIDTH(DW), .ALMOST_FULL_SLACK(SL)) dut (
        .clk(clk), .reset_n(reset_n),
        .afu_rd_req_valid(s_req_v), .afu_rd_req_addr(s_req_addr), .afu_rd_req_mdata(s_req_md),
        .afu_rd_req_almost_full(s_af),
        .qlp_rd_req_valid(s_qlp_v), .qlp_rd_req_addr(s_qlp_addr), .qlp_rd_req_mdata(s_qlp_md),
        .qlp_rd_req_almost_full(s_qlp_af),
        .qlp_rd_rsp_valid(s_rsp_v), .qlp_rd_rsp_mdata(s_rsp_md), .qlp_rd_rsp_data(s_rsp_data),
        .afu_rd_rsp_valid(s_afu_v), .afu_rd_rsp_mdata(s_afu_md), .afu_rd_rsp_data(s_afu_data),
        .rob_error(s_err));

    cci_mpf_shim_rob #(.SORT_READ_RESPONSES(0), .N_ENTRIES(N), .ADDR_WIDTH(AW),
                       .MDATA_WIDTH(MW), .DATA_WIDTH(DW), .ALMOST_FULL_SLACK(SL)) dut_pt (
        .clk(clk), .reset_n(reset_n),
        .afu_rd_req_valid(p_req_v), .afu_rd_req_addr(p_req_addr), .afu_rd_req_mdata(p_req_md),
        .afu_rd_req_almost_full(p_af),
        .qlp_rd_req_valid(p_qlp_v), .qlp_rd_req_addr(p_qlp_addr), .qlp_rd_req_mdata(p_qlp_md),
        .qlp_rd_req_almost_full(p_qlp_af),
        .qlp_rd_rsp_valid(p_rsp_v), .qlp_rd_rsp_mdata(p_rsp_md), .qlp_rd_rsp_data(p_rsp_data),
        .afu_rd_rsp_valid(p_afu_v), .afu_rd_rsp_mdata(p_afu_md), .afu_rd_rsp_data(p_afu_data),
        .rob_error(p_err));

    typedef struct {
        bit            sel;        // 0: sorting instance, 1: pass-through instance
        bit            req_v;
        logic [MW-1:0] req_md;
        bit            rsp_v;
        logic [MW-1:0] rsp_md;
        bit            qlp_af;
        bit            e_qv;
        logic [MW-1:0] e_qmd;
        bit            e_rv;
        logic [MW-1:0] e_rmd;
        logic [DW-1:0] e_rdata;
        bit            e_af;
        bit            e_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit sel, bit rv, logic [MW-1:0] rmd, bit pv, logic [MW-1:0] pmd,
                                bit qaf, bit eqv, logic [MW-1:0] eqmd, bit erv,
                                logic [MW-1:0] ermd, logic [DW-1:0] erd, bit eaf, bit eerr);
        vec_t v;
        v.sel = sel; v.req_v = rv; v.req_md = rmd; v.rsp_v = pv; v.rsp_md = pmd; v.qlp_af = qaf;
        v.e_qv = eqv; v.e_qmd = eqmd; v.e_rv = erv; v.e_rmd = ermd; v.e_rdata = erd;
        v.e_af = eaf; v.e_err = eerr;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        s_req_v = 1'b0; s_req_addr = '0; s_req_md = '0; s_qlp_af = 1'b0;
        s_rsp_v = 1'b0; s_rsp_md = '0; s_rsp_data = '0;
        p_req_v = 1'b0; p_req_addr = '0; p_req_md = '0; p_qlp_af = 1'b0;
        p_rsp_v = 1'b0; p_rsp_md = '0; p_rsp_data = '0;
    endtask

    task automatic sort_req(input logic [MW-1:0] md);
        s_req_v = 1'b1; s_req_md = md; s_req_addr = 16'h1000 | 16'(md);
    endtask

    task automatic do_reset(input string tag);
        idle();
        reset_n = 1'b0;
        #1;
        check({tag, " rst qlp_valid"},   64'(s_qlp_v), 64'(0));
        check({tag, " rst afu_valid"},   64'(s_afu_v), 64'(0));
        check({tag, " rst almost_full"}, 64'(s_af),    64'(0));
        check({tag, " rst rob_error"},   64'(s_err),   64'(0));
        check({tag, " rst pt valids"},   64'({p_qlp_v, p_afu_v, p_af, p_err}), 64'(0));
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic          o_qv, o_rv, o_af, o_err;
        logic [MW-1:0] o_qmd, o_rmd;
        logic [AW-1:0] o_qaddr;
        logic [DW-1:0] o_rdata;
        vec_t v;

        // Out-of-order return (slots 3,2,1,0) must come back as A0..A3.
        vecs.push_back(mk(0, 1, 8'hA0, 0, 8'h00, 0, 1, 8'h0, 0, 8'h00, 32'h0, 0, 0));
        vecs.push_back(mk(0, 1, 8'hA1, 0, 8'h00, 0, 1, 8'h1, 0, 8'h00, 32'h0, 0, 0));
        vecs.push_back(mk(0, 1, 8'hA2, 0, 8'h00, 0, 1, 8'h2, 0, 8'h00, 32'h0, 0, 0));
        vecs.push_back(mk(0, 1, 8'hA3, 0, 8'h00, 0, 1, 8'h3, 0, 8'h00, 32'h0, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 8'h03, 0, 0, 8'h0, 0, 8'h00, 32'h0, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 8'h02, 0, 0, 8'h0, 0, 8'h00, 32'h0, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 8'h01, 0, 0, 8'h0, 0, 8'h00, 32'h0, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 8'h00, 0, 0, 8'h0, 0, 8'h00, 32'h0, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h0, 1, 8'hA0, 32'hD000_0000, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h0, 1, 8'hA1, 32'hD000_0001, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h0, 1, 8'hA2, 32'hD000_0002, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h0, 1, 8'hA3, 32'hD000_0003, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h0, 0, 8'h00, 32'h0, 0, 0));
        // Pass-through: mdata untouched, one-cycle registers, almost-full mirrored.
        vecs.push_back(mk(1, 1, 8'h55, 1, 8'h03, 0, 1, 8'h55, 1, 8'h03, 32'hD000_0003, 0, 0));
        vecs.push_back(mk(1, 0, 8'h00, 1, 8'h01, 1, 0, 8'h00, 1, 8'h01, 32'hD000_0001, 1, 0));
        vecs.push_back(mk(1, 1, 8'h66, 0, 8'h00, 0, 1, 8'h66, 0, 8'h00, 32'h0, 0, 0));

        do_reset("init");

        foreach (vecs[i]) begin
            v = vecs[i];
            idle();
            if (v.sel == 1'b0) begin
                s_req_v = v.req_v; s_req_md = v.req_md; s_req_addr = 16'h1000 | 16'(v.req_md);
                s_rsp_v = v.rsp_v; s_rsp_md = v.rsp_md; s_rsp_data = 32'hD000_0000 | 32'(v.rsp_md);
                s_qlp_af = v.qlp_af;
            end else begin
                p_req_v = v.req_v; p_req_md = v.req_md; p_req_addr = 16'h1000 | 16'(v.req_md);
                p_rsp_v = v.rsp_v; p_rsp_md = v.rsp_md; p_rsp_data = 32'hD000_0000 | 32'(v.rsp_md);
                p_qlp_af = v.qlp_af;
            end
            step();
            if (v.sel == 1'b0) begin
                o_qv = s_qlp_v; o_qmd = s_qlp_md; o_qaddr = s_qlp_addr; o_rv = s_afu_v;
                o_rmd = s_afu_md; o_rdata = s_afu_data; o_af = s_af; o_err = s_err;
            end else begin
                o_qv = p_qlp_v; o_qmd = p_qlp_md; o_qaddr = p_qlp_addr; o_rv = p_afu_v;
                o_rmd = p_afu_md; o_rdata = p_afu_data; o_af = p_af; o_err = p_err;
            end
            check($sformatf("vec%0d qlp_valid", i), 64'(o_qv), 64'(v.e_qv));
            if (v.e_qv) begin
                check($sformatf("vec%0d qlp_mdata", i), 64'(o_qmd), 64'(v.e_qmd));
                check($sformatf("vec%0d qlp_addr", i), 64'(o_qaddr), 64'(16'h1000 | 16'(v.req_md)));
            end
            check($sformatf("vec%0d afu_valid", i), 64'(o_rv), 64'(v.e_rv));
            if (v.e_rv) begin
                check($sformatf("vec%0d afu_mdata", i), 64'(o_rmd), 64'(v.e_rmd));
                check($sformatf("vec%0d afu_data", i), 64'(o_rdata), 64'(v.e_rdata));
            end
            check($sformatf("vec%0d almost_full", i), 64'(o_af), 64'(v.e_af));
            check($sformatf("vec%0d rob_error", i), 64'(o_err), 64'(v.e_err));
        end

        // Fill to capacity: almost-full after the 6th, two more accepted, 9th dropped.
        do_reset("full");
        for (int k = 0; k < 8; k++) begin
            idle();
            sort_req(8'(8'h20 + k));
            step();
            check($sformatf("full req%0d qlp_valid", k), 64'(s_qlp_v), 64'(1));
            check($sformatf("full req%0d qlp_mdata", k), 64'(s_qlp_md), 64'(k));
            check($sformatf("full req%0d almost_full", k), 64'(s_af), 64'(k >= 5));
            check($sformatf("full req%0d rob_error", k), 64'(s_err), 64'(0));
        end
        idle();
        sort_req(8'h28);
        step();
        check("full req8 qlp_valid", 64'(s_qlp_v), 64'(0));
        check("full req8 rob_error", 64'(s_err), 64'(1));
        check("full req8 almost_full", 64'(s_af), 64'(1));

        // Streaming: one allocate and one drain per cycle, pointers wrap past 16.
        do_reset("stream");
        for (int c = 0; c < 24; c++) begin
            idle();
            if (c < 20) sort_req(8'(8'h40 + c));
            if (c >= 1 && c <= 20) begin
                s_rsp_v = 1'b1; s_rsp_md = 8'((c - 1) % N); s_rsp_data = 32'hE000_0000 + 32'(c - 1);
            end
            step();
            if (c < 20)
                check($sformatf("stream c%0d qlp_mdata", c), 64'({s_qlp_v, s_qlp_md}), 64'({1'b1, 8'(c % N)}));
            check($sformatf("stream c%0d afu_valid", c), 64'(s_afu_v), 64'(c >= 2 && c <= 21));
            if (c >= 2 && c <= 21) begin
                check($sformatf("stream c%0d afu_mdata", c), 64'(s_afu_md), 64'(8'h40 + c - 2));
                check($sformatf("stream c%0d afu_data", c), 64'(s_afu_data), 64'(32'hE000_0000 + 32'(c - 2)));
            end
            check($sformatf("stream c%0d almost_full", c), 64'(s_af), 64'(0));
        end
        check("stream rob_error", 64'(s_err), 64'(0));

        // Response to an unallocated slot: dropped, sticky error, nothing emitted.
        do_reset("bad_rsp");
        for (int k = 0; k < 3; k++) begin
            idle();
            sort_req(8'(8'h10 + k));
            step();
        end
        idle();
        s_rsp_v = 1'b1; s_rsp_md = 8'h05; s_rsp_data = 32'hBAD0_0005;
        step();
        check("bad_rsp rob_error", 64'(s_err), 64'(1));
        check("bad_rsp afu_valid", 64'(s_afu_v), 64'(0));
        idle();
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("bad_rsp hold%0d afu_valid", k), 64'(s_afu_v), 64'(0));
            check($sformatf("bad_rsp hold%0d rob_error", k), 64'(s_err), 64'(1));
        end

        // Mid-operation reset with slots 0..2 outstanding, then a fresh request.
        sort_req(8'h77);
        step();
        check("midrst pre qlp_mdata", 64'({s_qlp_v, s_qlp_md}), 64'({1'b1, 8'h03}));
        idle();
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst async qlp_valid", 64'(s_qlp_v), 64'(0));
        check("midrst async rob_error", 64'(s_err), 64'(0));
        check("midrst async afu_valid", 64'({s_afu_v, s_af}), 64'(0));
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        #1;
        check("midrst release qlp_valid", 64'(s_qlp_v), 64'(0));
        sort_req(8'h88);
        step();
        check("midrst new qlp_mdata", 64'({s_qlp_v, s_qlp_md}), 64'({1'b1, 8'h00}));
        check("midrst new rob_error", 64'(s_err), 64'(0));
        idle();
        s_rsp_v = 1'b1; s_rsp_md = 8'h00; s_rsp_data = 32'hCAFE_0000;
        step();
        check("midrst rsp afu_valid early", 64'(s_afu_v), 64'(0));
        idle();
        step();
        check("midrst rsp afu_mdata", 64'({s_afu_v, s_afu_md}), 64'({1'b1, 8'h88}));
        check("midrst rsp afu_data", 64'(s_afu_data), 64'(32'hCAFE_0000));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/cci_mpf_shim_rob.md
CCI_MPF_SHIM_ROB -- requirements
Module: cci_mpf_shim_rob

Interface
REQ-001 SHALL have parameter SORT_READ_RESPONSES, default 1, 1 = in-order read responses, 0 = pass-through mode.
REQ-002 SHALL have parameter N_ENTRIES, default 64, reorder slots; power of two, 4..512; IDX_W = log2(N_ENTRIES).
REQ-003 SHALL have parameter ADDR_WIDTH, default 42, request line address width.
REQ-004 SHALL have parameter MDATA_WIDTH, default 16, request/response tag width; MDATA_WIDTH >= IDX_W.
REQ-005 SHALL have parameter DATA_WIDTH, default 512, read data width.
REQ-006 SHALL have parameter ALMOST_FULL_SLACK, default 8, requests the AFU may still issue after almost-full asserts; < N_ENTRIES.
REQ-007 Ports SHALL be: clk  in  1  sole clock; reset_n  in  1  asynchronous active-low reset.
REQ-008 afu_rd_req_valid  in  1 / afu_rd_req_addr  in  ADDR_WIDTH / afu_rd_req_mdata  in  MDATA_WIDTH  AFU read request.
REQ-009 afu_rd_req_almost_full  out  1  flow control to AFU.
REQ-010 qlp_rd_req_valid  out  1 / qlp_rd_req_addr  out  ADDR_WIDTH / qlp_rd_req_mdata  out  MDATA_WIDTH  request to QLP.
REQ-011 qlp_rd_req_almost_full  in  1  QLP flow control.
REQ-012 qlp_rd_rsp_valid  in  1 / qlp_rd_rsp_mdata  in  MDATA_WIDTH / qlp_rd_rsp_data  in  DATA_WIDTH  QLP response.
REQ-013 afu_rd_rsp_valid  out  1 / afu_rd_rsp_mdata  out  MDATA_WIDTH / afu_rd_rsp_data  out  DATA_WIDTH  AFU response.
REQ-014 rob_error  out  1  sticky protocol-error flag.

Function
REQ-015 Sort mode: each valid AFU request SHALL be forwarded to QLP the next cycle, registered, addr unchanged, qlp_rd_req_mdata = tail slot index zero-extended.
REQ-016 Sort mode: AFU mdata SHALL be stored in the metadata RAM at the tail slot; tail and pointers SHALL be IDX_W+1 bits, wrapping modulo 2*N_ENTRIES.
REQ-017 QLP response SHALL write data into slot qlp_rd_rsp_mdata[IDX_W-1:0] and set that slot's ready bit; responses arrive in any order.
REQ-018 When head slot is ready, it SHALL be emitted on afu_rd_rsp_* the next cycle with original AFU mdata, ready bit cleared, head incremented; max one response per cycle.
REQ-019 Minimum latency, QLP response to AFU response for the head slot SHALL be 2 cycles (RAM write, registered read-out).
REQ-020 Occupancy = tail - head; simultaneous allocate and drain SHALL leave occupancy unchanged.
REQ-021 afu_rd_req_almost_full SHALL be registered and asserted when occupancy >= N_ENTRIES - ALMOST_FULL_SLACK or qlp_rd_req_almost_full is 1.
REQ-022 Request arriving when occupancy == N_ENTRIES SHALL be dropped (not forwarded) and set rob_error.
REQ-023 Response whose slot is not allocated or already ready SHALL be dropped and set rob_error.
REQ-024 rob_error SHALL remain 1 until reset.
REQ-025 Pass-through mode: request and response paths SHALL each be a one-cycle register, mdata unmodified; afu_rd_req_almost_full = registered qlp_rd_req_almost_full; no slot state; rob_error stays 0.
REQ-026 Data RAM contents SHALL NOT be reset; only control state is reset.

Reset
REQ-027 While reset_n = 0, all valid outputs, afu_rd_req_almost_full and rob_error SHALL be 0; head = tail = 0; all ready bits cleared.
REQ-028 Reset asserted mid-operation SHALL abandon all outstanding slots immediately; first valid output no earlier than first clk edge after reset_n rises.

Verification
REQ-029 N_ENTRIES=8: 4 requests mdata 0xA0..0xA3, responses returned in slot order 3,2,1,0 -> AFU sees mdata 0xA0,0xA1,0xA2,0xA3 in order, the first 2 cycles after slot 0 response.
REQ-030 N_ENTRIES=8, SLACK=2: issue 6 requests, no responses -> almost_full = 1 the cycle after 6th request; issue 2 more OK, 9th -> dropped, rob_error = 1.
REQ-031 Continuous stream, 20 requests with in-order responses, one allocate + one drain per cycle -> occupancy constant, pointers wrap past 16, all 20 delivered in order, rob_error = 0.
REQ-032 Response with mdata = 5 when only slots 0..2 allocated -> dropped, rob_error = 1, no AFU response emitted.
REQ-033 SORT_READ_RESPONSES=0: responses mdata 0x3,0x1 -> AFU sees 0x3 then 0x1, each 1 cycle later; requests forwarded with original mdata.
REQ-034 reset_n pulsed low with 3 slots outstanding -> outputs 0 immediately; after release, new request gets qlp mdata 0.
